// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg: shared state encoding, timing defaults and counter sizing for the clock controls
package time_set_ctrl_pkg;
  typedef enum logic [1:0] {NORMAL, SET_HOUR, SET_MIN, SET_SEC} state_t;
  localparam int REPEAT_START_DEF = 2;
  localparam int TIMEOUT_DEF = 30;
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: tick/button inputs and counter/display controls of the time-set block
interface time_set_ctrl_if;
  logic EN1HZ, EN4HZ, BTN_SEL, BTN_SET;
  logic CNT_EN, SEC_CLR, MIN_INC, HOUR_INC, MODE24, BLINK_H, BLINK_M, BLINK_S;
  modport master(
    output EN1HZ, EN4HZ, BTN_SEL, BTN_SET,
    input CNT_EN, SEC_CLR, MIN_INC, HOUR_INC, MODE24, BLINK_H, BLINK_M, BLINK_S
  );
  modport slave(
    input EN1HZ, EN4HZ, BTN_SEL, BTN_SET,
    output CNT_EN, SEC_CLR, MIN_INC, HOUR_INC, MODE24, BLINK_H, BLINK_M, BLINK_S
  );
endinterface

// File: rtl/btn_edge.sv
// btn_edge: rise detector for two button levels against their registered previous samples
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic a_rise,
  output logic b_rise
);
  logic a_q, b_q, a_d, b_d;
  always_comb begin
    a_d = a;
    b_d = b;
  end
  always_ff @(posedge clk) begin
    a_q <= rst ? 1'b0 : a_d;
    b_q <= rst ? 1'b0 : b_d;
  end
  assign a_rise = a & ~a_q;
  assign b_rise = b & ~b_q;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: select/set button FSM producing time-adjust pulses, 12/24h mode, blink and count gating
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int REPEAT_START = REPEAT_START_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic CLK,
  input logic RST,
  time_set_ctrl_if.slave bus
);
  localparam int W = cnt_w(REPEAT_START, TIMEOUT);
  localparam logic [W-1:0] RS = W'(REPEAT_START);
  localparam logic [W-1:0] TO = W'(TIMEOUT);
  state_t state_q, state_d;
  logic [W-1:0] rep_cnt_q, rep_cnt_d, to_cnt_q, to_cnt_d;
  logic mode24_q, mode24_d, phase_q, phase_d;
  logic hour_q, hour_d, min_q, min_d, clr_q, clr_d, cnt_en_q, cnt_en_d;
  logic blink_h_q, blink_h_d, blink_m_q, blink_m_d, blink_s_q, blink_s_d;
  logic sel_rise, set_rise, tmo, set_hit, rep_st, rep, chg;
  btn_edge u_edge (
    .clk(CLK),
    .rst(RST),
    .a(bus.BTN_SEL),
    .b(bus.BTN_SET),
    .a_rise(sel_rise),
    .b_rise(set_rise)
  );
  // a timeout overrides any simultaneous button action so the exit is silent
  always_comb begin
    tmo = state_q != NORMAL && to_cnt_q >= TO;
    set_hit = set_rise & ~sel_rise & ~tmo;
    rep_st = state_q == SET_HOUR || state_q == SET_MIN;
    rep = rep_st & bus.BTN_SET & bus.EN4HZ & (rep_cnt_q >= RS) & ~sel_rise & ~tmo;
    state_d = tmo ? NORMAL : sel_rise ? state_t'(state_q + 2'd1) : state_q;
    chg = state_d != state_q;
    hour_d = (set_hit | rep) & state_q == SET_HOUR;
    min_d = (set_hit | rep) & state_q == SET_MIN;
    clr_d = set_hit & state_q == SET_SEC;
    mode24_d = mode24_q ^ (set_hit & state_q == NORMAL);
    rep_cnt_d = (!bus.BTN_SET || chg || !rep_st) ? '0
              : (bus.EN4HZ && rep_cnt_q < RS) ? rep_cnt_q + W'(1) : rep_cnt_q;
    to_cnt_d = (state_d == NORMAL || chg || sel_rise || set_rise || rep) ? '0
             : (bus.EN1HZ && to_cnt_q < TO) ? to_cnt_q + W'(1) : to_cnt_q;
    phase_d = (hour_d | min_d | clr_d) ? 1'b0 : phase_q ^ bus.EN4HZ;
    blink_h_d = phase_d & state_d == SET_HOUR;
    blink_m_d = phase_d & state_d == SET_MIN;
    blink_s_d = phase_d & state_d == SET_SEC;
    cnt_en_d = bus.EN1HZ & state_d != SET_SEC;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= NORMAL;
      rep_cnt_q <= '0;
      to_cnt_q <= '0;
      mode24_q <= 1'b1;
      phase_q <= 1'b0;
      {hour_q, min_q, clr_q, cnt_en_q} <= '0;
      {blink_h_q, blink_m_q, blink_s_q} <= '0;
    end else begin
      state_q <= state_d;
      rep_cnt_q <= rep_cnt_d;
      to_cnt_q <= to_cnt_d;
      mode24_q <= mode24_d;
      phase_q <= phase_d;
      {hour_q, min_q, clr_q, cnt_en_q} <= {hour_d, min_d, clr_d, cnt_en_d};
      {blink_h_q, blink_m_q, blink_s_q} <= {blink_h_d, blink_m_d, blink_s_d};
    end
  end
  assign bus.CNT_EN = cnt_en_q;
  assign bus.SEC_CLR = clr_q;
  assign bus.MIN_INC = min_q;
  assign bus.HOUR_INC = hour_q;
  assign bus.MODE24 = mode24_q;
  assign bus.BLINK_H = blink_h_q;
  assign bus.BLINK_M = blink_m_q;
  assign bus.BLINK_S = blink_s_q;
endmodule
